// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared CPU definitions used by the instruction fetch stage:
//   fetchState_t      - fetch FSM state encoding
//   RESET_PC_DEFAULT  - default first fetch address after reset
//   NOP_INSTR         - instruction word injected on flush/bubble
//   alignPc()         - forces a target address onto a word boundary
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request outstanding at PCF
    HOLD  = 2'd1,  // word buffered, decode stalled, no request
    DRAIN = 2'd2   // waiting out a wrong-path response
  } fetchState_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register.
//   Clk, Reset         - clock, synchronous active-high reset
//   Enable             - load new contents (decode not stalled)
//   Clear              - load a NOP bubble; PCPlus4D keeps its value
//   InstrIn/PCPlus4In  - instruction and its PC+4 from fetch
//   InstrD/PCPlus4D    - registered instruction and PC+4
//   ValidD             - register holds a real instruction
// -----------------------------------------------------------------------------
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        Clear,
  input  logic [31:0] InstrIn,
  input  logic [31:0] PCPlus4In,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  logic [31:0] instrReg;
  logic [31:0] pcPlus4Reg;
  logic        validReg;

  // Clear wins over a normal load so a flush can never leak a wrong-path word.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      instrReg   <= NOP_INSTR;
      pcPlus4Reg <= 32'h0;
      validReg   <= 1'b0;
    end else if (Clear) begin
      instrReg <= NOP_INSTR;
      validReg <= 1'b0;
    end else if (Enable) begin
      instrReg   <= InstrIn;
      pcPlus4Reg <= PCPlus4In;
      validReg   <= 1'b1;
    end
  end

  assign InstrD   = instrReg;
  assign PCPlus4D = pcPlus4Reg;
  assign ValidD   = validReg;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch: PC register, fetch FSM (FETCH/HOLD/DRAIN) handling a
// variable-latency instruction memory, branch/jump redirect and the IF/ID
// register.
//   Clk, Reset            - clock, synchronous active-high reset
//   StallF, StallD        - hazard-unit stalls for PCF and IF/ID
//   PCSrcD/PCBranchD      - taken branch and its target
//   JumpD/PCJumpD         - jump and its target (wins over a branch)
//   ImemReq/ImemAddr      - memory request, held stable until ImemReady
//   ImemReady/ImemRdata   - response strobe and instruction word
//   InstrD/PCPlus4D/ValidD- IF/ID register contents
//   FetchStall            - fetch cannot deliver this cycle
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchStall
);

  fetchState_t stateReg, stateNext;
  logic [31:0] pcfReg, pcfNext;
  logic [31:0] pendingPcReg, pendingPcNext;
  logic [31:0] holdBufReg, holdBufNext;

  logic        redirect;
  logic [31:0] redirectTarget;
  logic [31:0] pcfPlus4;
  logic        deliver;
  logic [31:0] deliverInstr;
  logic        ifIdClear;

  // A redirect is only acted on when decode actually advances.
  assign redirect       = (PCSrcD | JumpD) & ~StallD;
  assign redirectTarget = alignPc(JumpD ? PCJumpD : PCBranchD);
  assign pcfPlus4       = pcfReg + 32'd4;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateReg     <= FETCH;
      pcfReg       <= RESET_PC;
      pendingPcReg <= 32'h0;
      holdBufReg   <= 32'h0;
    end else begin
      stateReg     <= stateNext;
      pcfReg       <= pcfNext;
      pendingPcReg <= pendingPcNext;
      holdBufReg   <= holdBufNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    pcfNext       = pcfReg;
    pendingPcNext = pendingPcReg;
    holdBufNext   = holdBufReg;
    deliver       = 1'b0;
    deliverInstr  = holdBufReg;

    case (stateReg)
      FETCH: begin
        if (ImemReady) begin
          if (redirect) begin
            pcfNext = redirectTarget;
          end else if (StallD) begin
            holdBufNext = ImemRdata;
            stateNext   = HOLD;
          end else begin
            deliver      = 1'b1;
            deliverInstr = ImemRdata;
            if (!StallF) pcfNext = pcfPlus4;
          end
        end else if (redirect) begin
          // The in-flight request must complete at the old address first.
          pendingPcNext = redirectTarget;
          stateNext     = DRAIN;
        end
      end

      HOLD: begin
        if (redirect) begin
          pcfNext   = redirectTarget;
          stateNext = FETCH;
        end else if (!StallD) begin
          deliver      = 1'b1;
          deliverInstr = holdBufReg;
          pcfNext      = pcfPlus4;
          stateNext    = FETCH;
        end
      end

      DRAIN: begin
        if (ImemReady) begin
          // A redirect arriving on the drain cycle itself is the newest target.
          pcfNext   = redirect ? redirectTarget : pendingPcReg;
          stateNext = FETCH;
        end else if (redirect) begin
          pendingPcNext = redirectTarget;
        end
      end

      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // Flush on redirect; bubble whenever decode advances with nothing to give.
  assign ifIdClear = redirect | (~StallD & ~deliver);

  if_id_reg ifIdReg (
    .Clk      (Clk),
    .Reset    (Reset),
    .Enable   (~StallD),
    .Clear    (ifIdClear),
    .InstrIn  (deliverInstr),
    .PCPlus4In(pcfPlus4),
    .InstrD   (InstrD),
    .PCPlus4D (PCPlus4D),
    .ValidD   (ValidD)
  );

  // In DRAIN pcfReg still holds the address of the outstanding request.
  assign ImemReq    = ~Reset & (stateReg != HOLD);
  assign ImemAddr   = pcfReg;
  assign FetchStall = ((stateReg == FETCH) & ~ImemReady) | (stateReg == DRAIN);

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Bench for fetch_stage: a variable-latency memory model, a scoreboard of
// expected IF/ID deliveries and directed scenarios for streaming, latency,
// stalls, redirects, PC wrap and reset in HOLD/DRAIN.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic        StallF, StallD;
  logic        PCSrcD, JumpD;
  logic [31:0] PCBranchD, PCJumpD;
  logic        ImemReq, ImemReady;
  logic [31:0] ImemAddr, ImemRdata;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD, FetchStall;

  int checkCount = 0;
  int errorCount = 0;

  logic [63:0] sbQueue[$];  // {instr, pcPlus4}

  int memLatency = 0;
  int waitCnt    = 0;

  logic edgeStallD = 1'b1;
  logic edgeReset  = 1'b1;
  logic pendPrev   = 1'b0;
  logic [31:0] addrPrev = 32'h0;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .JumpD     (JumpD),
    .PCJumpD   (PCJumpD),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemReady (ImemReady),
    .ImemRdata (ImemRdata),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .FetchStall(FetchStall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  // Memory answers once the request has waited memLatency cycles.
  assign ImemReady = ImemReq && (waitCnt >= memLatency);
  assign ImemRdata = memWord(ImemAddr);

  always @(posedge Clk) begin
    if (!ImemReq || ImemReady) waitCnt <= 0;
    else                       waitCnt <= waitCnt + 1;
    edgeStallD <= StallD;
    edgeReset  <= Reset;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expectWord(input logic [31:0] addr);
    logic [31:0] pc4;
    pc4 = addr + 32'd4;
    sbQueue.push_back({memWord(addr), pc4});
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard: a new IF/ID load happened on the last edge if decode was not
  // stalled and reset was low; any valid load must match the queue head.
  // Also checks that an unanswered request stays stable.
  always @(negedge Clk) begin
    logic [63:0] item;
    if (!edgeReset && !edgeStallD && ValidD) begin
      if (sbQueue.size() == 0) begin
        checkVal("sbUnexpected", {31'h0, ValidD}, 32'h0);
      end else begin
        item = sbQueue.pop_front();
        checkVal("sbInstr", InstrD, item[63:32]);
        checkVal("sbPc4", PCPlus4D, item[31:0]);
        $display("deliver instr=0x%08h pc4=0x%08h", InstrD, PCPlus4D);
      end
    end
    if (pendPrev && !Reset) begin
      checkVal("reqStable", {31'h0, ImemReq}, 32'h1);
      checkVal("addrStable", ImemAddr, addrPrev);
    end
    pendPrev = ImemReq && !ImemReady && !Reset;
    addrPrev = ImemAddr;
  end

  initial begin
    Reset = 1'b1; StallF = 1'b0; StallD = 1'b0;
    PCSrcD = 1'b0; PCBranchD = 32'h0; JumpD = 1'b0; PCJumpD = 32'h0;

    // Reset state
    @(negedge Clk);
    checkVal("rstReq", {31'h0, ImemReq}, 32'h0);
    checkVal("rstValid", {31'h0, ValidD}, 32'h0);
    checkVal("rstInstr", InstrD, 32'h0);
    checkVal("rstPc4", PCPlus4D, 32'h0);
    tick();
    Reset = 1'b0;

    // Zero-latency streaming from 0
    for (int i = 0; i < 4; i++) begin
      expectWord(32'(i * 4));
      @(negedge Clk);
      checkVal("seqAddr", ImemAddr, 32'(i * 4));
      checkVal("seqStall", {31'h0, FetchStall}, 32'h0);
      if (i == 0) checkVal("firstReq", {31'h0, ImemReq}, 32'h1);
      if (i >= 1) checkVal("seqValid", {31'h0, ValidD}, 32'h1);
      tick();
    end

    // Three-cycle latency at 0x10
    memLatency = 3;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checkVal("latStall", {31'h0, FetchStall}, 32'h1);
      checkVal("latAddr", ImemAddr, 32'h10);
      if (k >= 1) checkVal("latBubble", {31'h0, ValidD}, 32'h0);
      tick();
    end
    expectWord(32'h10);
    @(negedge Clk);
    checkVal("latDone", {31'h0, FetchStall}, 32'h0);
    tick();

    // Word returns under stall -> HOLD for two cycles
    memLatency = 0; StallD = 1'b1; StallF = 1'b1;
    @(negedge Clk);
    checkVal("holdAddrA", ImemAddr, 32'h14);
    tick();
    @(negedge Clk);
    checkVal("holdReq", {31'h0, ImemReq}, 32'h0);
    checkVal("holdAddrB", ImemAddr, 32'h14);
    checkVal("holdInstrKept", InstrD, memWord(32'h10));
    checkVal("holdFetchStall", {31'h0, FetchStall}, 32'h0);
    tick();
    StallD = 1'b0; StallF = 1'b0;
    expectWord(32'h14);
    @(negedge Clk);
    checkVal("holdReqC", {31'h0, ImemReq}, 32'h0);
    tick();
    expectWord(32'h18);
    @(negedge Clk);
    checkVal("releaseAddr", ImemAddr, 32'h18);
    checkVal("releaseReq", {31'h0, ImemReq}, 32'h1);
    tick();

    // Branch while memory busy -> DRAIN
    memLatency = 3; PCSrcD = 1'b1; PCBranchD = 32'h40;
    @(negedge Clk);
    checkVal("drainStallE", {31'h0, FetchStall}, 32'h1);
    tick();
    PCSrcD = 1'b0;
    @(negedge Clk);
    checkVal("drainFlush", {31'h0, ValidD}, 32'h0);
    checkVal("drainAddr", ImemAddr, 32'h1C);
    checkVal("drainStallF", {31'h0, FetchStall}, 32'h1);
    tick();
    @(negedge Clk);
    checkVal("drainStallG", {31'h0, FetchStall}, 32'h1);
    tick();
    @(negedge Clk);
    checkVal("drainStallH", {31'h0, FetchStall}, 32'h1);
    tick();
    memLatency = 0;
    expectWord(32'h40);
    @(negedge Clk);
    checkVal("drainTarget", ImemAddr, 32'h40);
    checkVal("drainNoStale", {31'h0, ValidD}, 32'h0);
    tick();

    // Jump beats branch, target aligned; branch under StallD ignored
    JumpD = 1'b1; PCJumpD = 32'h83; PCSrcD = 1'b1; PCBranchD = 32'h40;
    @(negedge Clk);
    checkVal("jmpAddrJ", ImemAddr, 32'h44);
    tick();
    JumpD = 1'b0; StallD = 1'b1; StallF = 1'b1;
    @(negedge Clk);
    checkVal("jmpTarget", ImemAddr, 32'h80);
    checkVal("jmpFlush", {31'h0, ValidD}, 32'h0);
    tick();
    PCSrcD = 1'b0; StallD = 1'b0; StallF = 1'b0;
    expectWord(32'h80);
    @(negedge Clk);
    checkVal("stallBrIgnored", ImemAddr, 32'h80);
    checkVal("stallBrHold", {31'h0, ImemReq}, 32'h0);
    tick();
    expectWord(32'h84);
    @(negedge Clk);
    checkVal("afterHoldAddr", ImemAddr, 32'h84);
    tick();

    // Reset in HOLD
    StallD = 1'b1; StallF = 1'b1;
    @(negedge Clk);
    tick();
    Reset = 1'b1;
    @(negedge Clk);
    checkVal("rstHoldReq", {31'h0, ImemReq}, 32'h0);
    tick();
    Reset = 1'b0; StallD = 1'b0; StallF = 1'b0;
    expectWord(32'h0);
    @(negedge Clk);
    checkVal("rstHoldValid", {31'h0, ValidD}, 32'h0);
    checkVal("rstHoldInstr", InstrD, 32'h0);
    checkVal("rstHoldPc4", PCPlus4D, 32'h0);
    checkVal("rstHoldAddr", ImemAddr, 32'h0);
    checkVal("rstHoldReqOn", {31'h0, ImemReq}, 32'h1);
    tick();

    // Reset in DRAIN
    memLatency = 3; PCSrcD = 1'b1; PCBranchD = 32'h40;
    @(negedge Clk);
    checkVal("rstDrainAddrQ", ImemAddr, 32'h4);
    tick();
    PCSrcD = 1'b0; Reset = 1'b1;
    @(negedge Clk);
    checkVal("rstDrainState", {31'h0, FetchStall}, 32'h1);
    tick();
    Reset = 1'b0; memLatency = 0;
    expectWord(32'h0);
    @(negedge Clk);
    checkVal("rstDrainValid", {31'h0, ValidD}, 32'h0);
    checkVal("rstDrainInstr", InstrD, 32'h0);
    checkVal("rstDrainPc4", PCPlus4D, 32'h0);
    checkVal("rstDrainAddr", ImemAddr, 32'h0);
    checkVal("rstDrainReq", {31'h0, ImemReq}, 32'h1);
    tick();

    // PC wrap at 0xFFFF_FFFC
    JumpD = 1'b1; PCJumpD = 32'hFFFF_FFFC;
    @(negedge Clk);
    checkVal("wrapPreAddr", ImemAddr, 32'h4);
    tick();
    JumpD = 1'b0;
    expectWord(32'hFFFF_FFFC);
    @(negedge Clk);
    checkVal("wrapTopAddr", ImemAddr, 32'hFFFF_FFFC);
    tick();
    expectWord(32'h0);
    @(negedge Clk);
    checkVal("wrapZeroAddr", ImemAddr, 32'h0);
    tick();
    StallD = 1'b1; StallF = 1'b1;
    @(negedge Clk);
    tick();
    @(negedge Clk);
    checkVal("sbEmpty", 32'(sbQueue.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
